// File: rtl/conv_cfg_pkg.sv
// conv_cfg_pkg: shared definitions for the convolution runtime-configuration block.
//   - Word addresses of the config words inside one layer context.
//   - Bit positions inside the CTRL word.
//   - Issue FSM state type.
//   - ptr_width(): pointer width for a queue of a given depth (at least 1 bit).
package conv_cfg_pkg;

  // Config word addresses within a context
  localparam int unsigned CFG_CTRL        = 0;
  localparam int unsigned CFG_CALC        = 1;
  localparam int unsigned CFG_IFMAP_BASE  = 2;
  localparam int unsigned CFG_OFMAP_BASE  = 3;
  localparam int unsigned CFG_IFMAP_SHAPE = 4;
  localparam int unsigned CFG_KERNAL      = 5;
  localparam int unsigned CFG_BUF         = 6;
  localparam int unsigned CFG_OFMAP_SHAPE = 7;

  // CTRL word bit positions
  localparam int unsigned EN_MAC_ARRAY = 0;
  localparam int unsigned EN_PACKER    = 1;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StRun   = 2'd2
  } conv_state_e;

  // A depth-1 queue still needs a 1-bit pointer to keep the vectors legal.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/conv_cfg_ctx_fifo.sv
// conv_cfg_ctx_fifo: DEPTH-entry synchronous FIFO of WIDTH-bit layer contexts.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   flush            empty the FIFO (wins over push/pop)
//   push, push_data  enqueue; accepted when not full, or when full with a same-cycle pop
//   pop, pop_data    dequeue; pop_data is the head entry, valid while not empty
//   full, empty      occupancy flags
//   count            number of stored entries
module conv_cfg_ctx_fifo
  import conv_cfg_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             pop_data,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PtrW = ptr_width(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (32'(p) == DEPTH - 1) ? '0 : p + PtrW'(1);
  endfunction

  assign empty    = (count_q == '0);
  assign full     = (count_q == CntW'(DEPTH));
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];

  // A pop in the same cycle frees the head slot, so a push into a full FIFO is still taken.
  assign do_pop  = pop & ~empty & ~flush;
  assign do_push = push & (~full | do_pop) & ~flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage needs no reset: entries are only read once counted in.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/conv_cfg_ctx_queue.sv
// conv_cfg_ctx_queue: runtime-configuration block for the convolution engine.
// The host fills a shadow bank of REG_N 32-bit words, commits it as a layer context into a
// CTX_N-deep queue, and queued contexts are issued one at a time with a start/done handshake.
// Ports:
//   clk, rst_n                              clock, asynchronous active-low reset
//   cfg_wen/waddr/wdata/wstrb               byte-masked shadow write
//   cfg_ren/raddr -> cfg_rdata/cfg_rvalid   registered shadow read (1-cycle latency)
//   commit -> commit_ack / commit_err       snapshot shadow into queue; ack or queue-full pulse
//   soft_abort                              flush queue, clear active context, return to idle
//   layer_start / layer_start_ready         start request for the active context
//   layer_done                              engine finished the active layer
//   active_cfg                              active context, word k at [32k+31:32k]
//   en_mac_array, en_packer                 active CTRL word bits
//   busy, ctx_cnt, irq                      not idle, queued contexts, layer-done interrupt pulse
module conv_cfg_ctx_queue
  import conv_cfg_pkg::*;
#(
  parameter int unsigned REG_N  = 16,
  parameter int unsigned CTX_N  = 2,
  parameter int unsigned ADDR_W = $clog2(REG_N)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         cfg_wen,
  input  logic [ADDR_W-1:0]            cfg_waddr,
  input  logic [31:0]                  cfg_wdata,
  input  logic [3:0]                   cfg_wstrb,
  input  logic                         cfg_ren,
  input  logic [ADDR_W-1:0]            cfg_raddr,
  output logic [31:0]                  cfg_rdata,
  output logic                         cfg_rvalid,
  input  logic                         commit,
  output logic                         commit_ack,
  output logic                         commit_err,
  input  logic                         soft_abort,
  output logic                         layer_start,
  input  logic                         layer_start_ready,
  input  logic                         layer_done,
  output logic [REG_N*32-1:0]          active_cfg,
  output logic                         en_mac_array,
  output logic                         en_packer,
  output logic                         busy,
  output logic [$clog2(CTX_N+1)-1:0]   ctx_cnt,
  output logic                         irq
);

  localparam int unsigned CfgW = REG_N * 32;

  // Shadow bank
  logic [REG_N-1:0][31:0] shadow_q, shadow_d;
  logic [31:0]            rdata_d, rdata_q;
  logic                   rvalid_q;

  // Issue FSM and active context
  conv_state_e            state_q, state_d;
  logic [CfgW-1:0]        active_q, active_d;
  logic                   pop;
  logic                   irq_d, irq_q;

  // Commit path
  logic                   push, push_ok;
  logic                   ack_q, err_q;

  // Queue
  logic [CfgW-1:0]        fifo_head;
  logic                   fifo_full, fifo_empty;

  // Byte-masked write; out-of-range addresses match no word and are dropped.
  always_comb begin
    shadow_d = shadow_q;
    for (int unsigned k = 0; k < REG_N; k++) begin
      if (cfg_wen && (32'(cfg_waddr) == k)) begin
        for (int unsigned b = 0; b < 4; b++) begin
          if (cfg_wstrb[b]) shadow_d[k][8*b +: 8] = cfg_wdata[8*b +: 8];
        end
      end
    end
  end

  // Reads see the pre-write bank; out-of-range addresses return 0.
  always_comb begin
    rdata_d = '0;
    for (int unsigned k = 0; k < REG_N; k++) begin
      if (32'(cfg_raddr) == k) rdata_d = shadow_q[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      rvalid_q <= cfg_ren;
      if (cfg_ren) rdata_q <= rdata_d;
    end
  end

  // Issue FSM: pops happen only here, and soft_abort overrides everything.
  always_comb begin
    state_d  = state_q;
    pop      = 1'b0;
    irq_d    = 1'b0;
    case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = StIssue;
        end
      end
      StIssue: begin
        if (layer_start_ready) state_d = StRun;
      end
      StRun: begin
        if (layer_done) begin
          irq_d = 1'b1;
          if (!fifo_empty) begin
            pop     = 1'b1;
            state_d = StIssue;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    if (soft_abort) begin
      state_d = StIdle;
      pop     = 1'b0;
      irq_d   = 1'b0;
    end
  end

  // Active context holds its last value when the queue runs dry.
  always_comb begin
    active_d = active_q;
    if (soft_abort) begin
      active_d = '0;
    end else if (pop) begin
      active_d = fifo_head;
    end
  end

  // Commit snapshots the post-write bank so a same-cycle write is included.
  assign push    = commit & ~soft_abort;
  assign push_ok = push & (~fifo_full | pop);

  conv_cfg_ctx_fifo #(
    .WIDTH (CfgW),
    .DEPTH (CTX_N)
  ) u_ctx_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (soft_abort),
    .push      (push_ok),
    .push_data (shadow_d),
    .pop       (pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (ctx_cnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      active_q <= '0;
      irq_q    <= 1'b0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      active_q <= active_d;
      irq_q    <= irq_d;
      ack_q    <= push_ok;
      err_q    <= push & ~push_ok;
    end
  end

  assign cfg_rdata    = rdata_q;
  assign cfg_rvalid   = rvalid_q;
  assign commit_ack   = ack_q;
  assign commit_err   = err_q;
  assign irq          = irq_q;
  assign active_cfg   = active_q;
  assign en_mac_array = active_q[EN_MAC_ARRAY];
  assign en_packer    = active_q[EN_PACKER];
  assign layer_start  = (state_q == StIssue);
  assign busy         = (state_q != StIdle);

endmodule

// File: tb/tb_conv_cfg_ctx_queue.sv
// Bench for conv_cfg_ctx_queue: directed scenarios followed by random traffic, all checked
// against a transaction-level model (shadow array, context queue, phase variable).
module tb_conv_cfg_ctx_queue;

  localparam int REG_N  = 16;
  localparam int CTX_N  = 2;
  localparam int ADDR_W = 5;  // one spare bit so out-of-range addresses are reachable
  localparam int CW     = REG_N * 32;
  localparam int CNT_W  = $clog2(CTX_N + 1);

  localparam int PH_IDLE  = 0;
  localparam int PH_ISSUE = 1;
  localparam int PH_RUN   = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              cfg_wen;
  logic [ADDR_W-1:0] cfg_waddr;
  logic [31:0]       cfg_wdata;
  logic [3:0]        cfg_wstrb;
  logic              cfg_ren;
  logic [ADDR_W-1:0] cfg_raddr;
  logic [31:0]       cfg_rdata;
  logic              cfg_rvalid;
  logic              commit;
  logic              commit_ack;
  logic              commit_err;
  logic              soft_abort;
  logic              layer_start;
  logic              layer_start_ready;
  logic              layer_done;
  logic [CW-1:0]     active_cfg;
  logic              en_mac_array;
  logic              en_packer;
  logic              busy;
  logic [CNT_W-1:0]  ctx_cnt;
  logic              irq;

  always #5 clk = ~clk;

  conv_cfg_ctx_queue #(
    .REG_N  (REG_N),
    .CTX_N  (CTX_N),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .cfg_wen           (cfg_wen),
    .cfg_waddr         (cfg_waddr),
    .cfg_wdata         (cfg_wdata),
    .cfg_wstrb         (cfg_wstrb),
    .cfg_ren           (cfg_ren),
    .cfg_raddr         (cfg_raddr),
    .cfg_rdata         (cfg_rdata),
    .cfg_rvalid        (cfg_rvalid),
    .commit            (commit),
    .commit_ack        (commit_ack),
    .commit_err        (commit_err),
    .soft_abort        (soft_abort),
    .layer_start       (layer_start),
    .layer_start_ready (layer_start_ready),
    .layer_done        (layer_done),
    .active_cfg        (active_cfg),
    .en_mac_array      (en_mac_array),
    .en_packer         (en_packer),
    .busy              (busy),
    .ctx_cnt           (ctx_cnt),
    .irq               (irq)
  );

  // Reference model state
  logic [31:0] m_shadow [REG_N];
  logic [CW-1:0] m_q [$];
  logic [CW-1:0] m_active;
  int          m_phase;
  logic [31:0] m_rdata;
  logic        m_rvalid, m_ack, m_err, m_irq;

  int n_pass;
  int n_total;

  task automatic check(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    for (int k = 0; k < REG_N; k++) m_shadow[k] = '0;
    m_q.delete();
    m_active = '0;
    m_phase  = PH_IDLE;
    m_rdata  = '0;
    m_rvalid = 1'b0;
    m_ack    = 1'b0;
    m_err    = 1'b0;
    m_irq    = 1'b0;
  endtask

  // One clock of the behavioural rules, using the inputs present at the edge.
  task automatic model_step();
    int ra;
    int wa;
    logic [CW-1:0] snap;
    ra = int'(cfg_raddr);
    wa = int'(cfg_waddr);
    m_rvalid = cfg_ren;
    if (cfg_ren) m_rdata = (ra < REG_N) ? m_shadow[ra] : 32'h0;
    if (cfg_wen && wa < REG_N) begin
      for (int b = 0; b < 4; b++) begin
        if (cfg_wstrb[b]) m_shadow[wa][8*b +: 8] = cfg_wdata[8*b +: 8];
      end
    end
    for (int k = 0; k < REG_N; k++) snap[32*k +: 32] = m_shadow[k];
    m_ack = 1'b0;
    m_err = 1'b0;
    m_irq = 1'b0;
    if (soft_abort) begin
      m_q.delete();
      m_active = '0;
      m_phase  = PH_IDLE;
    end else begin
      if (m_phase == PH_IDLE) begin
        if (m_q.size() > 0) begin
          m_active = m_q.pop_front();
          m_phase  = PH_ISSUE;
        end
      end else if (m_phase == PH_ISSUE) begin
        if (layer_start_ready) m_phase = PH_RUN;
      end else if (layer_done) begin
        m_irq = 1'b1;
        if (m_q.size() > 0) begin
          m_active = m_q.pop_front();
          m_phase  = PH_ISSUE;
        end else begin
          m_phase = PH_IDLE;
        end
      end
      // Any pop above has already freed its slot.
      if (commit) begin
        if (m_q.size() < CTX_N) begin
          m_q.push_back(snap);
          m_ack = 1'b1;
        end else begin
          m_err = 1'b1;
        end
      end
    end
  endtask

  task automatic compare_all();
    check("rvalid", CW'(cfg_rvalid), CW'(m_rvalid));
    if (m_rvalid) check("rdata", CW'(cfg_rdata), CW'(m_rdata));
    check("commit_ack", CW'(commit_ack), CW'(m_ack));
    check("commit_err", CW'(commit_err), CW'(m_err));
    check("irq", CW'(irq), CW'(m_irq));
    check("ctx_cnt", CW'(ctx_cnt), CW'(m_q.size()));
    check("layer_start", CW'(layer_start), CW'(m_phase == PH_ISSUE));
    check("busy", CW'(busy), CW'(m_phase != PH_IDLE));
    check("active_cfg", active_cfg, m_active);
    check("en_mac_array", CW'(en_mac_array), CW'(m_active[0]));
    check("en_packer", CW'(en_packer), CW'(m_active[1]));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic clear_inputs();
    cfg_wen           = 1'b0;
    cfg_waddr         = '0;
    cfg_wdata         = '0;
    cfg_wstrb         = '0;
    cfg_ren           = 1'b0;
    cfg_raddr         = '0;
    commit            = 1'b0;
    soft_abort        = 1'b0;
    layer_start_ready = 1'b0;
    layer_done        = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst_n   = 1'b0;
    clear_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    check("reset_rdata", CW'(cfg_rdata), CW'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Byte-masked write, same-cycle read returns the old value
    cfg_wen = 1'b1; cfg_waddr = 3; cfg_wdata = 32'h12345678; cfg_wstrb = 4'b0101;
    cfg_ren = 1'b1; cfg_raddr = 3;
    tick();
    check("rd_same_cycle", CW'(cfg_rdata), CW'(0));
    clear_inputs(); cfg_ren = 1'b1; cfg_raddr = 3;
    tick();
    check("rd_word3", CW'(cfg_rdata), CW'(32'h00340078));
    check("rd_word3_valid", CW'(cfg_rvalid), CW'(1));
    clear_inputs(); cfg_ren = 1'b1; cfg_raddr = ADDR_W'(REG_N);
    tick();
    check("rd_oob", CW'(cfg_rdata), CW'(0));
    check("rd_oob_valid", CW'(cfg_rvalid), CW'(1));
    clear_inputs();
    tick();
    check("rvalid_idle", CW'(cfg_rvalid), CW'(0));

    // Commit with a same-cycle CTRL write into an empty queue
    cfg_wen = 1'b1; cfg_waddr = ADDR_W'(conv_cfg_pkg::CFG_CTRL); cfg_wdata = 32'h3;
    cfg_wstrb = 4'hf; commit = 1'b1;
    tick();
    check("c1_ack", CW'(commit_ack), CW'(1));
    check("c1_cnt_t1", CW'(ctx_cnt), CW'(1));
    check("c1_start_t1", CW'(layer_start), CW'(0));
    clear_inputs();
    tick();
    check("c1_start_t2", CW'(layer_start), CW'(1));
    check("c1_en_mac", CW'(en_mac_array), CW'(1));
    check("c1_en_packer", CW'(en_packer), CW'(1));
    check("c1_cnt_t2", CW'(ctx_cnt), CW'(0));
    tick();
    check("c1_start_held", CW'(layer_start), CW'(1));
    layer_start_ready = 1'b1;
    tick();
    layer_start_ready = 1'b0;
    check("c1_run_start", CW'(layer_start), CW'(0));
    check("c1_run_busy", CW'(busy), CW'(1));

    // Three commits while running: two accepted, third rejected
    commit = 1'b1;
    tick();
    check("q_ack1", CW'(commit_ack), CW'(1));
    tick();
    check("q_ack2", CW'(commit_ack), CW'(1));
    tick();
    check("q_err", CW'(commit_err), CW'(1));
    check("q_err_noack", CW'(commit_ack), CW'(0));
    check("q_full_cnt", CW'(ctx_cnt), CW'(2));
    commit = 1'b0; layer_done = 1'b1;
    tick();
    layer_done = 1'b0;
    check("b2b_irq", CW'(irq), CW'(1));
    check("b2b_start", CW'(layer_start), CW'(1));
    check("b2b_cnt", CW'(ctx_cnt), CW'(1));
    tick();
    check("irq_pulse", CW'(irq), CW'(0));

    // Refill, then commit and done together on a full queue
    layer_start_ready = 1'b1;
    tick();
    layer_start_ready = 1'b0; commit = 1'b1;
    tick();
    check("refill_cnt", CW'(ctx_cnt), CW'(2));
    layer_done = 1'b1;
    tick();
    clear_inputs();
    check("full_pop_ack", CW'(commit_ack), CW'(1));
    check("full_pop_cnt", CW'(ctx_cnt), CW'(2));
    check("full_pop_start", CW'(layer_start), CW'(1));

    // Soft abort in ISSUE with two queued; the concurrent commit is dropped
    soft_abort = 1'b1; commit = 1'b1;
    tick();
    clear_inputs();
    check("abort_cnt", CW'(ctx_cnt), CW'(0));
    check("abort_active", active_cfg, CW'(0));
    check("abort_start", CW'(layer_start), CW'(0));
    check("abort_noack", CW'(commit_ack | commit_err), CW'(0));
    cfg_ren = 1'b1; cfg_raddr = 3;
    tick();
    check("abort_shadow3", CW'(cfg_rdata), CW'(32'h00340078));
    cfg_raddr = 0;
    tick();
    check("abort_shadow0", CW'(cfg_rdata), CW'(32'h3));
    clear_inputs();

    // Reset mid-RUN, later layer_done ignored
    commit = 1'b1;
    tick();
    commit = 1'b0;
    tick();
    layer_start_ready = 1'b1;
    tick();
    layer_start_ready = 1'b0;
    check("pre_reset_busy", CW'(busy), CW'(1));
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    compare_all();
    check("reset_busy", CW'(busy), CW'(0));
    check("reset_active", active_cfg, CW'(0));
    layer_done = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    layer_done = 1'b0;
    check("post_reset_irq", CW'(irq), CW'(0));
    check("post_reset_busy", CW'(busy), CW'(0));

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      cfg_wen           = ($urandom_range(0, 2) == 0);
      cfg_waddr         = ADDR_W'($urandom_range(0, REG_N + 1));
      cfg_wdata         = $urandom();
      cfg_wstrb         = 4'($urandom());
      cfg_ren           = ($urandom_range(0, 1) == 1);
      cfg_raddr         = ADDR_W'($urandom_range(0, REG_N + 1));
      commit            = ($urandom_range(0, 3) == 0);
      soft_abort        = ($urandom_range(0, 39) == 0);
      layer_start_ready = ($urandom_range(0, 1) == 1);
      layer_done        = ($urandom_range(0, 3) == 0);
      tick();
    end
    clear_inputs();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
